// File: rtl/char_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : char_blitter
//  Purpose  : Draws one glyph from an external glyph ROM as a stream of pixel
//             writes, with integer magnification m = scale+1 (1..4).
//  Options  : define CHAR_BLITTER_OPAQUE_EN to add bg_colour and plot clear
//             bits in the background colour (opaque text).
//  Revision : 1.0  initial release
// ============================================================================
module char_blitter #(
   parameter int GLYPH_W = 8,
   parameter int GLYPH_H = 10,
   parameter int CODE_W  = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [CODE_W-1:0]   char_code,
   input  logic [7:0]          origin_x,
   input  logic [7:0]          origin_y,
   input  logic [5:0]          colour,
`ifdef CHAR_BLITTER_OPAQUE_EN
   input  logic [5:0]          bg_colour,
`endif
   input  logic [1:0]          scale,
   output logic [CODE_W+3:0]   rom_addr,
   input  logic [GLYPH_W-1:0]  rom_data,
   output logic [7:0]          out_x,
   output logic [7:0]          out_y,
   output logic [5:0]          out_colour,
   output logic                plot,
   input  logic                plot_ready,
   output logic                busy,
   output logic                done
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_FETCH = 3'd1;
   localparam logic [2:0] c_LOAD  = 3'd2;
   localparam logic [2:0] c_DRAW  = 3'd3;
   localparam logic [2:0] c_DONE  = 3'd4;

   localparam logic [3:0] c_COL_LAST = 4'(GLYPH_W - 1);
   localparam logic [3:0] c_ROW_LAST = 4'(GLYPH_H - 1);

   logic [2:0]          r_state;
   logic [CODE_W-1:0]   r_code;
   logic [7:0]          r_ox;
   logic [7:0]          r_oy;
   logic [5:0]          r_colour;
   logic [1:0]          r_scale;
   logic [GLYPH_W-1:0]  r_bits;
   logic [3:0]          r_row;
   logic [1:0]          r_sy;
   logic [3:0]          r_col;
   logic [1:0]          r_sx;
   logic [7:0]          r_last_x;
   logic [7:0]          r_last_y;
   logic [5:0]          r_last_colour;
`ifdef CHAR_BLITTER_OPAQUE_EN
   logic [5:0]          r_bg;
`endif

   logic [2:0]          w_m;
   logic [GLYPH_W-1:0]  w_shift;
   logic                w_bit;
   logic [7:0]          w_x;
   logic [7:0]          w_y;
   logic                w_plot;
   logic [5:0]          w_pix_colour;
   logic                w_advance;
   logic                w_sx_last;
   logic                w_col_last;
   logic                w_sy_last;
   logic                w_row_last;

   // Current pixel position and bitmap bit; coordinates wrap modulo 256.
   assign w_m        = {1'b0, r_scale} + 3'd1;
   assign w_shift    = r_bits << r_col;
   assign w_bit      = w_shift[GLYPH_W-1];
   assign w_x        = r_ox + ({4'd0, r_col} * {5'd0, w_m}) + {6'd0, r_sx};
   assign w_y        = r_oy + ({4'd0, r_row} * {5'd0, w_m}) + {6'd0, r_sy};
   assign w_sx_last  = (r_sx == r_scale);
   assign w_sy_last  = (r_sy == r_scale);
   assign w_col_last = (r_col == c_COL_LAST);
   assign w_row_last = (r_row == c_ROW_LAST);

`ifdef CHAR_BLITTER_OPAQUE_EN
   assign w_plot       = (r_state == c_DRAW);
   assign w_pix_colour = w_bit ? r_colour : r_bg;
`else
   assign w_plot       = (r_state == c_DRAW) && w_bit;
   assign w_pix_colour = r_colour;
`endif

   // A plotted position waits for the framebuffer; a skipped one moves on.
   assign w_advance = (r_state == c_DRAW) && (!w_plot || plot_ready);

   assign rom_addr   = {r_code, r_row};
   assign plot       = w_plot;
   assign out_x      = w_plot ? w_x : r_last_x;
   assign out_y      = w_plot ? w_y : r_last_y;
   assign out_colour = w_plot ? w_pix_colour : r_last_colour;
   assign busy       = (r_state != c_IDLE);
   assign done       = (r_state == c_DONE);

   // Control FSM and the sx/col/sy/row scan counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= c_IDLE;
         r_code   <= '0;
         r_ox     <= '0;
         r_oy     <= '0;
         r_colour <= '0;
         r_scale  <= '0;
         r_bits   <= '0;
         r_row    <= '0;
         r_sy     <= '0;
         r_col    <= '0;
         r_sx     <= '0;
`ifdef CHAR_BLITTER_OPAQUE_EN
         r_bg     <= '0;
`endif
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_code   <= char_code;
                  r_ox     <= origin_x;
                  r_oy     <= origin_y;
                  r_colour <= colour;
                  r_scale  <= scale;
`ifdef CHAR_BLITTER_OPAQUE_EN
                  r_bg     <= bg_colour;
`endif
                  r_row    <= '0;
                  r_sy     <= '0;
                  r_col    <= '0;
                  r_sx     <= '0;
                  r_state  <= c_FETCH;
               end
            end
            c_FETCH: r_state <= c_LOAD;
            c_LOAD: begin
               r_bits  <= rom_data;
               r_state <= c_DRAW;
            end
            c_DRAW: begin
               if (w_advance) begin
                  if (!w_sx_last) begin
                     r_sx <= r_sx + 2'd1;
                  end else begin
                     r_sx <= '0;
                     if (!w_col_last) begin
                        r_col <= r_col + 4'd1;
                     end else begin
                        r_col <= '0;
                        if (!w_sy_last) begin
                           // Next sub-row reuses the latched bitmap.
                           r_sy <= r_sy + 2'd1;
                        end else begin
                           r_sy <= '0;
                           if (w_row_last) begin
                              r_state <= c_DONE;
                           end else begin
                              r_row   <= r_row + 4'd1;
                              r_state <= c_FETCH;
                           end
                        end
                     end
                  end
               end
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Remember the last plotted pixel so the outputs hold while plot is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_x      <= '0;
         r_last_y      <= '0;
         r_last_colour <= '0;
      end else if (w_plot) begin
         r_last_x      <= w_x;
         r_last_y      <= w_y;
         r_last_colour <= w_pix_colour;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_char_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_char_blitter
//  Purpose  : Self-checking bench for char_blitter: directed vector table,
//             reset-abort sequence and randomized glyphs against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_char_blitter;

   localparam int GW = 8;
   localparam int GH = 10;
   localparam int CW = 6;
`ifdef CHAR_BLITTER_OPAQUE_EN
   localparam bit OPAQ = 1'b1;
`else
   localparam bit OPAQ = 1'b0;
`endif

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [5:0] c;
   } plot_t;

   typedef struct {
      logic [5:0] code;
      logic [7:0] ox;
      logic [7:0] oy;
      logic [5:0] fg;
      logic [1:0] sc;
      int         mode;
      int         np;
      int         dk;
      int         fx;
      int         fy;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] char_code = '0;
   logic [7:0]    origin_x = '0;
   logic [7:0]    origin_y = '0;
   logic [5:0]    colour = '0;
   logic [5:0]    bg_colour = '0;
   logic [1:0]    scale = '0;
   logic [CW+3:0] rom_addr;
   logic [GW-1:0] rom_data;
   logic [7:0]    out_x;
   logic [7:0]    out_y;
   logic [5:0]    out_colour;
   logic          plot;
   logic          plot_ready = 1'b1;
   logic          busy;
   logic          done;

   logic [GW-1:0] rom_mem [0:(1<<(CW+4))-1];

   int n_vec  = 0;
   int n_fail = 0;

   char_blitter #(.GLYPH_W(GW), .GLYPH_H(GH), .CODE_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .char_code  (char_code),
      .origin_x   (origin_x),
      .origin_y   (origin_y),
      .colour     (colour),
`ifdef CHAR_BLITTER_OPAQUE_EN
      .bg_colour  (bg_colour),
`endif
      .scale      (scale),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_colour (out_colour),
      .plot       (plot),
      .plot_ready (plot_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Synchronous glyph ROM: data one cycle after the address.
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   function automatic void chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Draw one glyph and compare every accepted plot against a model built
   // from the drawing rules. mode 0: ready always; 1: 3-cycle stall on the
   // first plot; 2: random ready plus random start/input noise while busy.
   task automatic run_glyph(input logic [5:0] code, input logic [7:0] ox,
                            input logic [7:0] oy, input logic [5:0] fg,
                            input logic [5:0] bg, input logic [1:0] sc,
                            input int mode, output int np, output int dk,
                            output int fx, output int fy);
      plot_t         exp_q[$];
      plot_t         p;
      int            m;
      int            k;
      int            stalls;
      logic          prev_stall;
      logic [7:0]    hx;
      logic [7:0]    hy;
      logic [5:0]    hc;
      logic [GW-1:0] row_bits;
      m = int'(sc) + 1;
      hx = '0; hy = '0; hc = '0;
      for (int r = 0; r < GH; r++) begin
         row_bits = rom_mem[{code, 4'(r)}];
         for (int sy = 0; sy < m; sy++)
            for (int c = 0; c < GW; c++)
               for (int sx = 0; sx < m; sx++) begin
                  p.x = 8'((int'(ox) + c*m + sx) % 256);
                  p.y = 8'((int'(oy) + r*m + sy) % 256);
                  if (row_bits[GW-1-c]) begin
                     p.c = fg;
                     exp_q.push_back(p);
                  end else if (OPAQ) begin
                     p.c = bg;
                     exp_q.push_back(p);
                  end
               end
      end

      @(posedge clk); #1;
      char_code = code; origin_x = ox; origin_y = oy; colour = fg;
      bg_colour = bg; scale = sc; plot_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      np = 0; dk = -1; fx = -1; fy = -1; stalls = 0; prev_stall = 1'b0; k = 1;
      chk("busy_in_fetch", int'(busy), 1);
      while (k < 8000) begin
         case (mode)
            0:       plot_ready = 1'b1;
            1:       plot_ready = !(plot && np == 0 && stalls < 3);
            default: plot_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (prev_stall) begin
            chk("hold_plot", int'(plot), 1);
            chk("hold_x", int'(out_x), int'(hx));
            chk("hold_y", int'(out_y), int'(hy));
            chk("hold_colour", int'(out_colour), int'(hc));
         end
         if (plot && plot_ready) begin
            if (np == 0) begin
               fx = int'(out_x);
               fy = int'(out_y);
            end
            if (np < exp_q.size()) begin
               chk("plot_x", int'(out_x), int'(exp_q[np].x));
               chk("plot_y", int'(out_y), int'(exp_q[np].y));
               chk("plot_colour", int'(out_colour), int'(exp_q[np].c));
            end
            np++;
         end
         prev_stall = plot && !plot_ready;
         if (prev_stall) begin
            stalls++;
            hx = out_x; hy = out_y; hc = out_colour;
         end
         if (done) begin
            dk = k;
            start = 1'b0;
            break;
         end
         if (mode == 2) begin
            start     = 1'($urandom);
            char_code = 6'($urandom);
            origin_x  = 8'($urandom);
            origin_y  = 8'($urandom);
            colour    = 6'($urandom);
            bg_colour = 6'($urandom);
            scale     = 2'($urandom);
         end
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      plot_ready = 1'b1;
      chk("plot_count", np, exp_q.size());
      chk("done_cycle", dk, 1 + GH*(2 + m*m*GW) + stalls);
      if (dk >= 0) begin
         @(posedge clk); #1;
         chk("busy_after_done", int'(busy), 0);
         chk("done_one_cycle", int'(done), 0);
      end
   endtask

   initial begin
      vec_t vt[5];
      int   np, dk, fx, fy, got;

      for (int i = 0; i < (1 << (CW+4)); i++) rom_mem[i] = GW'($urandom);
      for (int r = 0; r < GH; r++) begin
         rom_mem[{6'd0, 4'(r)}] = '0;
         rom_mem[{6'd1, 4'(r)}] = '0;
         rom_mem[{6'd2, 4'(r)}] = '0;
      end
      rom_mem[{6'd1, 4'd0}] = 8'h80;
      rom_mem[{6'd2, 4'd0}] = 8'h10;

      // Directed vectors: blank glyph, single pixel at m=2, same with stall,
      // x wrap at origin 254, and m=4 wrapping at the 255 corner.
      vt[0] = '{code:6'd0, ox:8'd5,   oy:8'd7,   fg:6'h11, sc:2'd0, mode:0,
                np:(OPAQ ? 80 : 0),    dk:101,  fx:(OPAQ ? 5 : -1),   fy:(OPAQ ? 7 : -1)};
      vt[1] = '{code:6'd1, ox:8'd10,  oy:8'd20,  fg:6'h2A, sc:2'd1, mode:0,
                np:(OPAQ ? 320 : 4),   dk:341,  fx:10,  fy:20};
      vt[2] = '{code:6'd1, ox:8'd10,  oy:8'd20,  fg:6'h2A, sc:2'd1, mode:1,
                np:(OPAQ ? 320 : 4),   dk:344,  fx:10,  fy:20};
      vt[3] = '{code:6'd2, ox:8'd254, oy:8'd33,  fg:6'h07, sc:2'd0, mode:0,
                np:(OPAQ ? 80 : 1),    dk:101,  fx:(OPAQ ? 254 : 1),  fy:33};
      vt[4] = '{code:6'd1, ox:8'd255, oy:8'd255, fg:6'h3F, sc:2'd3, mode:0,
                np:(OPAQ ? 1280 : 16), dk:1301, fx:255, fy:255};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_plot", int'(plot), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_out_x", int'(out_x), 0);
      chk("rst_out_y", int'(out_y), 0);
      chk("rst_out_colour", int'(out_colour), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_glyph(vt[i].code, vt[i].ox, vt[i].oy, vt[i].fg, 6'h15, vt[i].sc,
                   vt[i].mode, np, dk, fx, fy);
         chk("vec_plots", np, vt[i].np);
         chk("vec_done_cycle", dk, vt[i].dk);
         chk("vec_first_x", fx, vt[i].fx);
         chk("vec_first_y", fy, vt[i].fy);
      end

      // Reset in the middle of DRAW aborts the glyph without a done pulse.
      @(posedge clk); #1;
      char_code = 6'd1; origin_x = 8'd10; origin_y = 8'd20; colour = 6'h2A;
      scale = 2'd1; plot_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_busy_before", int'(busy), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_plot", int'(plot), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_out_x", int'(out_x), 0);
      got = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done || busy) got++;
      end
      chk("abort_no_done", got, 0);
      run_glyph(6'd1, 8'd10, 8'd20, 6'h2A, 6'h15, 2'd1, 0, np, dk, fx, fy);
      chk("restart_plots", np, OPAQ ? 320 : 4);

      // Randomized glyphs against the model.
      for (int i = 0; i < 12; i++) begin
         run_glyph(6'($urandom_range(3, 63)), 8'($urandom), 8'($urandom),
                   6'($urandom), 6'($urandom), 2'($urandom), 2,
                   np, dk, fx, fy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/char_blitter.md
CHAR_BLITTER -- requirements
Module: char_blitter

Interface
REQ-001 SHALL have parameter GLYPH_W, default 8: glyph row width in pixels, 1..16.
REQ-002 SHALL have parameter GLYPH_H, default 10: glyph height in rows, 1..16.
REQ-003 SHALL have parameter CODE_W, default 6: character code width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to draw one glyph; sampled only in IDLE.
REQ-007 char_code  in  CODE_W  glyph index.
REQ-008 origin_x, origin_y  in  8 each  top-left pixel of the glyph.
REQ-009 colour  in  6  foreground colour.
REQ-010 scale  in  2  magnification m = scale+1 (1..4).
REQ-011 rom_addr  out  CODE_W+4  {char_code, row} to the external glyph ROM.
REQ-012 rom_data  in  GLYPH_W  row bitmap; MSB is the leftmost pixel; valid one cycle after rom_addr.
REQ-013 out_x, out_y  out  8 each  pixel coordinate; out_colour  out  6.
REQ-014 plot  out  1  pixel write valid; plot_ready  in  1  framebuffer accepts.
REQ-015 busy  out  1  high outside IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-016 SHALL use FSM states IDLE, FETCH, LOAD, DRAW, DONE.
REQ-017 IDLE with start=1 SHALL latch char_code, origin, colour and scale, clear row/sub-row/column/sub-column counters, and go to FETCH.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 FETCH SHALL drive rom_addr = {code, row} for one cycle, then go to LOAD.
REQ-020 LOAD SHALL capture rom_data into a row register, then go to DRAW.
REQ-021 DRAW SHALL scan the row in this order: sub-column sx innermost, then column col, then sub-row sy; sx and sy run over 0..m-1.
REQ-022 Each position SHALL take out_x = origin_x + col*m + sx and out_y = origin_y + row*m + sy, truncated modulo 256 (wrap-around).
REQ-023 A set bit SHALL assert plot with out_colour = colour; the position SHALL advance only on a cycle where plot && plot_ready.
REQ-024 A clear bit SHALL take one cycle with plot=0 and advance unconditionally.
REQ-025 While plot=1 and plot_ready=0, out_x, out_y, out_colour and plot SHALL hold stable.
REQ-026 At the end of a sub-row the next sub-row SHALL reuse the latched row without a refetch; at the end of sub-row m-1 the FSM SHALL go to FETCH for row+1, or to DONE after row GLYPH_H-1.
REQ-027 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-028 With plot_ready held at 1, the glyph SHALL take exactly GLYPH_H*(2+m*m*GLYPH_W) cycles from FETCH entry to DONE entry, whatever the bitmap.
REQ-029 Latency: start in cycle T gives FETCH at T+1, LOAD at T+2 and the first DRAW position at T+3.
REQ-030 When plot=0, out_x, out_y and out_colour SHALL hold their last values.

Reset
REQ-031 reset SHALL take priority over all other inputs and put the FSM in IDLE on the next edge, including when reset is asserted mid-glyph.
REQ-032 After reset: plot=0, busy=0, done=0, out_x=0, out_y=0, out_colour=0, rom_addr=0, all counters 0.
REQ-033 A glyph aborted by reset SHALL NOT produce done.

Configuration
REQ-034 Macro CHAR_BLITTER_OPAQUE_EN: when defined, input bg_colour [5:0] SHALL exist, and clear bits SHALL plot bg_colour with the same handshake as set bits.
REQ-035 When CHAR_BLITTER_OPAQUE_EN is undefined, bg_colour SHALL be absent and clear bits SHALL follow REQ-024 (transparent).

Verification
REQ-036 All-zero bitmap, m=1, 8x10 glyph, plot_ready=1, start at T -> no plot; done at T+101; busy low at T+102.
REQ-037 Only row 0 MSB set, origin (10,20), scale=1, colour=6'h2A -> exactly 4 plots, in order (10,20), (11,20), (10,21), (11,21), each with out_colour=6'h2A.
REQ-038 Same stimulus as REQ-037 with plot_ready low for 3 cycles on the first plot -> (10,20) held for 4 cycles; the plot sequence is unchanged and done is delayed by 3 cycles.
REQ-039 origin_x=254, only row 0 column 3 set, m=1 -> a single plot at out_x=1, out_y=origin_y.
REQ-040 reset asserted during DRAW -> next cycle plot=0, busy=0, done never pulses; a fresh start then completes normally.
REQ-041 With CHAR_BLITTER_OPAQUE_EN defined, m=1, any bitmap, plot_ready=1 -> exactly 80 plots, clear bits carrying bg_colour.
